soc_system_sysid_checker: RTL

- Avalon-MM read master at the far end of the system-ID slave interface.
- After reset, or on a start pulse, it reads word 0 (system ID) and word 1 (build timestamp) from the sysid slave and compares both against expected values.
- It reports match, mismatch or timeout status. The status gates bring-up logic, such as holding the shared-memory GPIO bridge until the FPGA image is confirmed.

---
 rtl/soc_system_sysid_pkg.sv | 25 ++
 rtl/soc_system_sysid_timeout_cnt.sv | 44 ++++
 rtl/soc_system_sysid_checker.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/soc_system_sysid_pkg.sv
// Shared types and constants for the system-ID checker: FSM states,
// sysid slave word addresses and the default expected image identity.
package soc_system_sysid_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARM   = 3'd1,
        RD_ID = 3'd2,
        WT_ID = 3'd3,
        RD_TS = 3'd4,
        WT_TS = 3'd5,
        DONE  = 3'd6
    } sysid_state_e;

    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

    localparam logic [31:0] SYSID_DEFAULT_ID = 32'hACD51314;
    localparam logic [31:0] SYSID_DEFAULT_TS = 32'h5A7C8CA7;

    function automatic logic word_differs(input logic [31:0] got, input logic [31:0] want);
        return (got != want);
    endfunction

endpackage

// File: rtl/soc_system_sysid_timeout_cnt.sv
// 16-bit up-counter with synchronous clear, load and enable, flagging when
// the count equals a terminal value.
module soc_system_sysid_timeout_cnt
    import soc_system_sysid_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        load,
    input  logic [15:0] load_val,
    input  logic        en,
    input  logic [15:0] tc_val,
    output logic        tc
);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    // Next count: clear beats load beats increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = 16'd0;
        end else if (load) begin
            cnt_d = load_val;
        end else if (en) begin
            cnt_d = cnt_q + 16'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == tc_val);

endmodule

// File: rtl/soc_system_sysid_checker.sv
// Avalon-MM read master that fetches sysid word 0 (ID) and word 1 (build
// timestamp), compares them with the expected image and reports status.
module soc_system_sysid_checker
    import soc_system_sysid_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID    = SYSID_DEFAULT_ID,
    parameter logic [31:0] EXPECTED_TS    = SYSID_DEFAULT_TS,
    parameter bit          CHECK_TS       = 1'b1,
    parameter bit          AUTO_START     = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 32'd1024
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        id_mismatch,
    output logic        ts_mismatch,
    output logic        timeout,
    output logic [31:0] sysid_value,
    output logic [31:0] sysid_timestamp
);

    localparam logic [15:0]  TC_VALUE    = 16'(TIMEOUT_CYCLES - 32'd1);
    localparam sysid_state_e RESET_STATE = AUTO_START ? ARM : IDLE;

    sysid_state_e state_q, state_d;
    logic         avm_read_q, avm_read_d;
    logic         avm_address_q, avm_address_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic         pass_q, pass_d;
    logic         id_mismatch_q, id_mismatch_d;
    logic         ts_mismatch_q, ts_mismatch_d;
    logic         timeout_q, timeout_d;
    logic [31:0]  sysid_value_q, sysid_value_d;
    logic [31:0]  sysid_timestamp_q, sysid_timestamp_d;

    logic cnt_clr_s;
    logic cnt_en_s;
    logic cnt_tc_s;
    logic rd_phase_s;
    logic ts_phase_s;
    logic data_taken_s;
    logic id_bad_s;
    logic ts_bad_s;

    soc_system_sysid_timeout_cnt u_timeout_cnt (
        .clk      (clock),
        .rst_n    (reset_n),
        .clr      (cnt_clr_s),
        .load     (1'b0),
        .load_val (16'd0),
        .en       (cnt_en_s),
        .tc_val   (TC_VALUE),
        .tc       (cnt_tc_s)
    );

    assign rd_phase_s   = (state_q == RD_ID) || (state_q == RD_TS);
    assign ts_phase_s   = (state_q == RD_TS) || (state_q == WT_TS);
    // Zero-latency slaves return data in the acceptance cycle itself.
    assign data_taken_s = rd_phase_s ? (!avm_waitrequest && avm_readdatavalid) : avm_readdatavalid;
    assign id_bad_s     = word_differs(sysid_value_q, EXPECTED_ID);
    assign ts_bad_s     = word_differs(sysid_timestamp_q, EXPECTED_TS);

    // Next-state, bus request and status computation.
    always_comb begin
        state_d           = state_q;
        avm_read_d        = 1'b0;
        avm_address_d     = avm_address_q;
        busy_d            = busy_q;
        done_d            = done_q;
        pass_d            = pass_q;
        id_mismatch_d     = id_mismatch_q;
        ts_mismatch_d     = ts_mismatch_q;
        timeout_d         = timeout_q;
        sysid_value_d     = sysid_value_q;
        sysid_timestamp_d = sysid_timestamp_q;
        cnt_clr_s         = 1'b0;
        cnt_en_s          = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d       = RD_ID;
                    avm_read_d    = 1'b1;
                    avm_address_d = SYSID_ADDR_ID;
                    busy_d        = 1'b1;
                    done_d        = 1'b0;
                    pass_d        = 1'b0;
                    id_mismatch_d = 1'b0;
                    ts_mismatch_d = 1'b0;
                    timeout_d     = 1'b0;
                    cnt_clr_s     = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            ARM: begin
                state_d       = RD_ID;
                avm_read_d    = 1'b1;
                avm_address_d = SYSID_ADDR_ID;
                busy_d        = 1'b1;
                cnt_clr_s     = 1'b1;
            end
            RD_ID, WT_ID, RD_TS, WT_TS: begin
                cnt_en_s = 1'b1;
                if (data_taken_s) begin
                    if (ts_phase_s) begin
                        sysid_timestamp_d = avm_readdata;
                        state_d           = DONE;
                    end else begin
                        sysid_value_d = avm_readdata;
                        state_d       = RD_TS;
                        avm_read_d    = 1'b1;
                        avm_address_d = SYSID_ADDR_TS;
                        cnt_clr_s     = 1'b1;
                    end
                end else if (cnt_tc_s) begin
                    // Only the ID can have been captured when a timeout hits.
                    state_d       = IDLE;
                    busy_d        = 1'b0;
                    done_d        = 1'b1;
                    pass_d        = 1'b0;
                    timeout_d     = 1'b1;
                    id_mismatch_d = ts_phase_s && id_bad_s;
                    ts_mismatch_d = 1'b0;
                end else if (rd_phase_s && avm_waitrequest) begin
                    avm_read_d = 1'b1;
                end else if (rd_phase_s) begin
                    state_d = ts_phase_s ? WT_TS : WT_ID;
                end else begin
                    state_d = state_q;
                end
            end
            DONE: begin
                state_d       = IDLE;
                busy_d        = 1'b0;
                done_d        = 1'b1;
                id_mismatch_d = id_bad_s;
                ts_mismatch_d = CHECK_TS && ts_bad_s;
                timeout_d     = 1'b0;
                pass_d        = !id_bad_s && !(CHECK_TS && ts_bad_s);
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, bus request, status and capture registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q           <= RESET_STATE;
            avm_read_q        <= 1'b0;
            avm_address_q     <= 1'b0;
            busy_q            <= 1'b0;
            done_q            <= 1'b0;
            pass_q            <= 1'b0;
            id_mismatch_q     <= 1'b0;
            ts_mismatch_q     <= 1'b0;
            timeout_q         <= 1'b0;
            sysid_value_q     <= 32'd0;
            sysid_timestamp_q <= 32'd0;
        end else begin
            state_q           <= state_d;
            avm_read_q        <= avm_read_d;
            avm_address_q     <= avm_address_d;
            busy_q            <= busy_d;
            done_q            <= done_d;
            pass_q            <= pass_d;
            id_mismatch_q     <= id_mismatch_d;
            ts_mismatch_q     <= ts_mismatch_d;
            timeout_q         <= timeout_d;
            sysid_value_q     <= sysid_value_d;
            sysid_timestamp_q <= sysid_timestamp_d;
        end
    end

    assign avm_address     = avm_address_q;
    assign avm_read        = avm_read_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign pass            = pass_q;
    assign id_mismatch     = id_mismatch_q;
    assign ts_mismatch     = ts_mismatch_q;
    assign timeout         = timeout_q;
    assign sysid_value     = sysid_value_q;
    assign sysid_timestamp = sysid_timestamp_q;

endmodule
